// File: rtl/wt_sched_gen.sv
// -----------------------------------------------------------------------------
// wt_sched_gen
//
// SHA-2 message schedule generator. It takes a padded message as an AXI-Stream
// of S_AXIS_DATA_WIDTH-bit beats, loads each block into a 16-word window, then
// streams W(0)..W(63) (SHA-224/256) or W(0)..W(79) (SHA-384/512), one word per
// m_axis handshake.
//
// Ports
//   axi_aclk, reset        clock and synchronous active-high reset
//   sha_type[1:0]          algorithm select, sampled when en is seen in IDLE;
//                          msb=1 selects 64-bit words
//   en                     start request (IDLE only)
//   s_axis_*               padded message input; tlast marks the last beat
//   m_axis_tdata/tvalid/   W(t) output; tlast marks the final word of the
//   tready/tlast           message
//   m_axis_tuser[6:0]      round index t of the word on m_axis_tdata
//   busy                   high whenever the scheduler is not idle
//   error                  one-cycle pulse when tlast arrives mid-block
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for en; both streams quiet
// LOAD  | accepting beats of one block into the 16-word window
// EMIT  | streaming W(t) and expanding the window on every handshake
// -----------------------------------------------------------------------------
module wt_sched_gen #(
    parameter int S_AXIS_DATA_WIDTH = 512,
    parameter int M_AXIS_DATA_WIDTH = 64
) (
    input  logic                         axi_aclk,
    input  logic                         reset,
    input  logic [1:0]                   sha_type,
    input  logic                         en,
    input  logic [S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [6:0]                   m_axis_tuser,
    output logic                         busy,
    output logic                         error
);

    localparam int BEATS_32 = 512 / S_AXIS_DATA_WIDTH;
    localparam int BEATS_64 = 1024 / S_AXIS_DATA_WIDTH;
    localparam int WORDS_32 = S_AXIS_DATA_WIDTH / 32;
    localparam int WORDS_64 = S_AXIS_DATA_WIDTH / 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        mode_q;       // 1 = 64-bit words
    logic [4:0]  beat_q;
    logic        fin_q;
    logic [6:0]  t_q;
    logic [63:0] win_q [16];
    logic        err_q;

    logic        last_beat;
    logic        last_word;
    logic [31:0] sum32;
    logic [63:0] sum64;
    logic [63:0] w_next;

    // 224/256 and 384/512 share the same schedule; only the width bit matters.
    logic        unused_sha_lsb;
    assign unused_sha_lsb = sha_type[0];

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [63:0] bswap64(input logic [63:0] x);
        return {bswap32(x[31:0]), bswap32(x[63:32])};
    endfunction

    function automatic logic [31:0] sig0_32(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1_32(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [63:0] sig0_64(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction

    function automatic logic [63:0] sig1_64(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

    assign last_beat = (beat_q == (mode_q ? 5'(BEATS_64 - 1) : 5'(BEATS_32 - 1)));
    assign last_word = (t_q == (mode_q ? 7'd79 : 7'd63));

    // Window holds W(t)..W(t+15), so W(t+16) uses slots 14, 9, 1 and 0.
    assign sum32  = sig1_32(win_q[14][31:0]) + win_q[9][31:0]
                  + sig0_32(win_q[1][31:0]) + win_q[0][31:0];
    assign sum64  = sig1_64(win_q[14]) + win_q[9] + sig0_64(win_q[1]) + win_q[0];
    assign w_next = mode_q ? sum64 : {32'h0, sum32};

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        busy          = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (last_beat) begin
                        state_d = ST_EMIT;
                    end else if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_EMIT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = fin_q && last_word;
                if (m_axis_tready && last_word) begin
                    state_d = fin_q ? ST_IDLE : ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            mode_q <= 1'b0;
            beat_q <= '0;
            fin_q  <= 1'b0;
            t_q    <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        mode_q <= sha_type[1];
                        beat_q <= '0;
                        fin_q  <= 1'b0;
                        t_q    <= '0;
                    end
                end
                ST_LOAD: begin
                    if (s_axis_tvalid) begin
                        // Byte 0 of the stream sits in tdata[7:0]; words are big-endian.
                        if (mode_q) begin
                            for (int k = 0; k < WORDS_64; k++) begin
                                win_q[4'(int'(beat_q) * WORDS_64 + k)] <=
                                    bswap64(s_axis_tdata[64*k +: 64]);
                            end
                        end else begin
                            for (int k = 0; k < WORDS_32; k++) begin
                                win_q[4'(int'(beat_q) * WORDS_32 + k)] <=
                                    {32'h0, bswap32(s_axis_tdata[32*k +: 32])};
                            end
                        end
                        if (last_beat) begin
                            beat_q <= '0;
                            fin_q  <= s_axis_tlast;
                            t_q    <= '0;
                        end else if (s_axis_tlast) begin
                            beat_q <= '0;
                            err_q  <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 5'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (m_axis_tready) begin
                        for (int i = 0; i < 15; i++) begin
                            win_q[i] <= win_q[i+1];
                        end
                        win_q[15] <= w_next;
                        t_q       <= last_word ? 7'd0 : t_q + 7'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_axis_tdata = M_AXIS_DATA_WIDTH'(mode_q ? win_q[0] : {32'h0, win_q[0][31:0]});
    assign m_axis_tuser = t_q;
    assign error        = err_q;

endmodule

// File: doc/wt_sched_gen.md
WT_SCHED_GEN -- requirements
Module: wt_sched_gen

Interface
REQ-001 SHALL have parameter S_AXIS_DATA_WIDTH, default 512: slave beat width; legal values 64, 128, 256, 512.
REQ-002 SHALL have parameter M_AXIS_DATA_WIDTH, default 64: W(t) output width; fixed at 64.
REQ-003 SHALL have port axi_aclk, input, 1: clock; all logic rises on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sha_type, input, 2: 00=SHA-224, 01=SHA-256, 10=SHA-384, 11=SHA-512; msb=1 selects 64-bit mode.
REQ-006 SHALL have port en, input, 1: scheduler start request.
REQ-007 SHALL have ports s_axis_tdata (S_AXIS_DATA_WIDTH), s_axis_tvalid/s_axis_tlast (1, in) and s_axis_tready (1, out): padded message stream; tlast marks the final beat of the message.
REQ-008 SHALL have ports m_axis_tdata (64, out), m_axis_tvalid/m_axis_tlast (1, out) and m_axis_tready (1, in): W(t) stream.
REQ-009 SHALL have port m_axis_tuser, output, 7: round index t of the current word.
REQ-010 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-011 SHALL have port error, output, 1: one-cycle pulse on a framing error.

Function
REQ-012 SHALL implement three states: IDLE, LOAD and EMIT.
REQ-013 IDLE: s_axis_tready=0 and m_axis_tvalid=0; when en=1, latch sha_type into mode and go to LOAD on the next cycle; sha_type and en are ignored outside IDLE.
REQ-014 Block size SHALL be 512 bits (32-bit mode) or 1024 bits (64-bit mode); beats per block = block size / S_AXIS_DATA_WIDTH, counted by a beat counter.
REQ-015 Byte order: s_axis_tdata[7:0] of the first beat is message byte 0. Word j is the big-endian concatenation of message bytes j*4..j*4+3 (32-bit mode) or j*8..j*8+7 (64-bit mode).
REQ-016 LOAD: s_axis_tready=1; each accepted beat fills the next words of the 16-entry window.
REQ-017 On acceptance of the final beat of a block, go to EMIT with s_axis_tready=0 on the next cycle; if s_axis_tlast=1 on that beat, set finish.
REQ-018 If s_axis_tlast=1 on a non-final beat of a block: pulse error for 1 cycle, discard the block, go to IDLE and emit nothing.
REQ-019 EMIT: m_axis_tvalid=1 starting the cycle after the last beat is accepted; m_axis_tdata=window[0] and m_axis_tuser=t, starting at t=0.
REQ-020 On each m_axis handshake: shift the window down by one, load window[15]=sigma1(W[14])+W[9]+sigma0(W[1])+W[0], and increment t.
REQ-021 All arithmetic in REQ-020 SHALL be modulo 2^32 in 32-bit mode and modulo 2^64 in 64-bit mode.
REQ-022 In 32-bit mode, m_axis_tdata[63:32] SHALL be 0.
REQ-023 32-bit sigma functions: sigma0 = ROTR7^ROTR18^SHR3; sigma1 = ROTR17^ROTR19^SHR10. Rotations act on 32 bits.
REQ-024 64-bit sigma functions: sigma0 = ROTR1^ROTR8^SHR7; sigma1 = ROTR19^ROTR61^SHR6.
REQ-025 Words per block SHALL be 64 in 32-bit mode and 80 in 64-bit mode; one word per cycle while m_axis_tready=1.
REQ-026 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tuser and m_axis_tlast SHALL hold stable.
REQ-027 m_axis_tlast=1 SHALL coincide exactly with the final word (t=63 or t=79) of a block that has finish set; it is 0 otherwise.
REQ-028 On the handshake of the final word: if finish, go to IDLE; else go to LOAD with s_axis_tready=1 on the next cycle and t=0.
REQ-029 s_axis_tready and m_axis_tvalid SHALL never be high in the same cycle.

Reset
REQ-030 When reset=1 at a clock edge, the block SHALL enter IDLE, clear t, beat count, finish and the window, and drive s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tuser, busy and error to 0.
REQ-031 Reset SHALL take priority over every other event, including a reset asserted mid-LOAD or mid-EMIT; no partial block survives reset.

Verification
REQ-032 SHA-256 "abc" (1 beat, width 512; bytes 61 62 63 80 then zeros, byte 63=0x18; tlast=1) -> t0=0x61626380, t15=0x18, t16=0x61626380, t17=0x000F0000, tlast only at t=63, then IDLE.
REQ-033 SHA-512 "abc" (2 beats; last beat tlast=1) -> t0=0x6162638000000000, t16=0x6162638000000000, t17=0x00030000000000C0, tlast at t=79.
REQ-034 Backpressure: m_axis_tready toggled randomly -> same 64-word sequence as REQ-032, with outputs stable during stalls.
REQ-035 Two-block SHA-256 message: no tlast at block-1 t=63; s_axis_tready=1 the cycle after that handshake; tlast only at block-2 t=63.
REQ-036 Width 128, SHA-256: s_axis_tlast on beat 2 of 4 -> error pulses 1 cycle, no m_axis_tvalid, state IDLE.
REQ-037 Reset at t=30 in EMIT -> all outputs 0 on the next cycle; a fresh "abc" afterward reproduces REQ-032 exactly.
